tone_detector: RTL
==================

// Module: tone_detector
// PURPOSE
//  Receive end of the note->square-wave tone path. Measures the half-period of an incoming
//  square wave (e.g. the tone generator output looped back or an external source) and maps it
//  to the 5-bit note code used by the generator (7..25 = note, 0 = none).
//  Reports a note code only after STABLE_COUNT consecutive matching half-periods.
//  Feeds note-recognition/game logic.
// PARAMETERS
//  TOL_SHIFT     6       match tolerance = P >> TOL_SHIFT cycles (~1.6% at 6)
//  STABLE_COUNT  4       consecutive identical classifications needed to update note
//  TIMEOUT       400000  cycles without an edge before the tone is declared absent (< 2^19)
// PORTS
//  clock_in    in   1  system clock (50 MHz)
//  reset       in   1  asynchronous, active-high reset
//  enable      in   1  1 = detect; 0 = force silence (same as timeout)
//  tone_in     in   1  asynchronous square-wave input
//  note        out  5  last confirmed note code (0 = none)
//  note_valid  out  1  1-cycle pulse whenever note changes value
//  locked      out  1  1 while note != 0
// BEHAVIOUR
//  Pitch table (P, in clock_in cycles): 7:191116 8:180388 9:170264 10:160709 11:151689
//   12:143176 13:135135 14:127551 15:120394 16:113636 17:107259 18:101239 19:95554
//   20:90194 21:85132 22:80352 23:75842 24:71586 25:67569.
//   Expected half-period H_ref = P+1 (the generator toggles every P+1 cycles).
//  Reset values: note = 0, note_valid = 0, locked = 0, state = IDLE, counter = 0,
//   synchroniser = 0, candidate = 0, match_cnt = 0.
//  Input path: 2-flop synchroniser, then 1 register for edge detect. Both edges count.
//  Half-period counter: 19 bits. Cleared to 1 on every detected edge, otherwise +1,
//   saturating at TIMEOUT. H = counter value at the edge.
//  FSM:
//   IDLE  : first edge -> ARMED. No classification.
//   ARMED : edge -> latch H and go to SCAN; counter restarts.
//           Counter == TIMEOUT -> IDLE.
//   SCAN  : exactly 19 cycles, index 7..25, one entry per cycle.
//           Match when |H - (P+1)| <= (P >> TOL_SHIFT); the first match wins;
//           no match gives result 0. Then go to ARMED.
//           Edges during SCAN restart the counter but are not classified.
//  Debounce (at SCAN exit):
//   - result == candidate: match_cnt += 1, saturating at STABLE_COUNT.
//   - otherwise: candidate = result, match_cnt = 1.
//   - match_cnt reaches STABLE_COUNT with candidate != note: on the next cycle,
//     note <= candidate, note_valid = 1 for one cycle, locked = (candidate != 0).
//  Latency: the update lands 23 cycles after the transition on tone_in is first sampled
//   (2 synchroniser + 1 edge + 19 scan + 1 update).
//  Timeout, or enable = 0:
//   - state = IDLE, candidate = 0, match_cnt = 0.
//   - If note != 0: note <= 0, one note_valid pulse, locked <= 0.
//   - enable = 0 holds the counter at 0.
//  Simultaneous events: timeout and edge in the same cycle -> the edge wins.
//   A SCAN exit and a timeout cannot coincide (TIMEOUT > 19).
//  Reset mid-operation: everything returns to reset values at once. A new lock needs
//   1 arming edge + STABLE_COUNT fresh measurements.
//  Width rules: all comparisons are unsigned 20-bit; |H - (P+1)| is computed without wrap.
// STRUCTURE
//  tone_defs.vh (shared with the tone generator):
//   - NOTE_NONE = 0, NOTE_MIN = 7, NOTE_MAX = 25, NOTE_HOLD = 31
//   - pitch-table constants P_7..P_25
//  Sub-module tone_pitch_rom: combinational index[4:0] -> P[18:0]; returns 0 outside 7..25.
//  FSM, counter, debounce: in tone_detector.
// TESTING
//  1. Square wave, H = 113637 (note 16) -> after arming edge + 4 half-periods: note = 16,
//     note_valid one pulse, locked = 1.
//  2. H = 114400 (|diff| 763 <= 1775) -> note = 16.
//     H = 115500 (diff 1863 > 1775, and no other entry matches) -> note stays 0.
//  3. Locked on 16, switch to H = 107260 -> note = 17 after 4 half-periods,
//     exactly one note_valid pulse, locked stays 1.
//  4. Locked, stop toggling -> TIMEOUT cycles after the last edge: note = 0, one pulse,
//     locked = 0.
//  5. Half-periods alternating 113637/107260 -> never locks; note stays 0, no pulses.
//  6. Assert reset during SCAN -> outputs 0 at once. After release, lock needs
//     1 + 4 edges of H = 67570 -> note = 25.

Source files
------------

// File: rtl/tone_detector_pkg.sv
// Shared definitions for the tone detector: note codes, FSM states
// and the half-period pitch table (in clock_in cycles).
package tone_detector_pkg;

    localparam logic [4:0] NOTE_NONE = 5'd0;
    localparam logic [4:0] NOTE_MIN  = 5'd7;
    localparam logic [4:0] NOTE_MAX  = 5'd25;
    localparam logic [4:0] NOTE_HOLD = 5'd31;

    localparam logic [18:0] P_7  = 19'd191116;
    localparam logic [18:0] P_8  = 19'd180388;
    localparam logic [18:0] P_9  = 19'd170264;
    localparam logic [18:0] P_10 = 19'd160709;
    localparam logic [18:0] P_11 = 19'd151689;
    localparam logic [18:0] P_12 = 19'd143176;
    localparam logic [18:0] P_13 = 19'd135135;
    localparam logic [18:0] P_14 = 19'd127551;
    localparam logic [18:0] P_15 = 19'd120394;
    localparam logic [18:0] P_16 = 19'd113636;
    localparam logic [18:0] P_17 = 19'd107259;
    localparam logic [18:0] P_18 = 19'd101239;
    localparam logic [18:0] P_19 = 19'd95554;
    localparam logic [18:0] P_20 = 19'd90194;
    localparam logic [18:0] P_21 = 19'd85132;
    localparam logic [18:0] P_22 = 19'd80352;
    localparam logic [18:0] P_23 = 19'd75842;
    localparam logic [18:0] P_24 = 19'd71586;
    localparam logic [18:0] P_25 = 19'd67569;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SCAN  = 2'd2
    } state_e;

    // |a - b| without wrap, both operands unsigned 20-bit
    function automatic logic [19:0] abs_diff(input logic [19:0] a,
                                             input logic [19:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/tone_pitch_rom.sv
// Pitch table lookup: note index -> generator period P.
// Indices outside NOTE_MIN..NOTE_MAX return 0.
module tone_pitch_rom
    import tone_detector_pkg::*;
(
    input  logic [4:0]  index_i,
    output logic [18:0] p_o
);

    // Pure combinational table
    always_comb begin
        p_o = '0;
        case (index_i)
            5'd7:    p_o = P_7;
            5'd8:    p_o = P_8;
            5'd9:    p_o = P_9;
            5'd10:   p_o = P_10;
            5'd11:   p_o = P_11;
            5'd12:   p_o = P_12;
            5'd13:   p_o = P_13;
            5'd14:   p_o = P_14;
            5'd15:   p_o = P_15;
            5'd16:   p_o = P_16;
            5'd17:   p_o = P_17;
            5'd18:   p_o = P_18;
            5'd19:   p_o = P_19;
            5'd20:   p_o = P_20;
            5'd21:   p_o = P_21;
            5'd22:   p_o = P_22;
            5'd23:   p_o = P_23;
            5'd24:   p_o = P_24;
            5'd25:   p_o = P_25;
            default: p_o = '0;
        endcase
    end

endmodule

// File: rtl/tone_detector.sv
// Square-wave half-period meter that classifies the measured period
// against the pitch table and debounces the result into a note code.
module tone_detector
    import tone_detector_pkg::*;
#(
    parameter int TOL_SHIFT    = 6,
    parameter int STABLE_COUNT = 4,
    parameter int TIMEOUT      = 400000,
    // Scales the pitch table down (P >> PITCH_SHIFT) for slower clocks
    parameter int PITCH_SHIFT  = 0
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       enable,
    input  logic       tone_in,
    output logic [4:0] note,
    output logic       note_valid,
    output logic       locked
);

    localparam int CW = $clog2(STABLE_COUNT + 1);
    localparam logic [18:0]   TMO    = 19'(TIMEOUT);
    localparam logic [CW-1:0] STABLE = CW'(STABLE_COUNT);

    logic          sync1_q, sync2_q, prev_q;
    logic          edge_s;
    logic [18:0]   cnt_q, cnt_d;
    logic          timeout_s;

    state_e        state_q, state_d;
    logic [18:0]   h_q, h_d;
    logic [4:0]    idx_q, idx_d;
    logic          found_q, found_d;
    logic [4:0]    res_q, res_d;
    logic [4:0]    cand_q, cand_d;
    logic [CW-1:0] mc_q, mc_d;
    logic [4:0]    note_q, note_d;
    logic          valid_q, valid_d;
    logic          locked_q, locked_d;

    logic [18:0]   rom_p;
    logic [18:0]   p_s;
    logic [19:0]   ref_s;
    logic [19:0]   tol_s;
    logic          hit_s;
    logic [4:0]    scan_res_s;

    tone_pitch_rom u_rom (
        .index_i (idx_q),
        .p_o     (rom_p)
    );

    // Input synchroniser plus one stage for edge detection
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= tone_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_s = sync2_q ^ prev_q;

    // Half-period counter: restart on edge, saturate at TIMEOUT
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (edge_s) begin
            cnt_d = 19'd1;
        end else if (cnt_q != TMO) begin
            cnt_d = cnt_q + 19'd1;
        end
    end

    // A coincident edge beats the timeout
    assign timeout_s = enable && !edge_s && (cnt_q == TMO);

    // Current table entry vs the latched half-period
    assign p_s   = rom_p >> PITCH_SHIFT;
    assign ref_s = {1'b0, p_s} + 20'd1;
    assign tol_s = {1'b0, p_s >> TOL_SHIFT};
    assign hit_s = abs_diff({1'b0, h_q}, ref_s) <= tol_s;

    // Final scan verdict, valid on the last scan cycle
    assign scan_res_s = found_q ? res_q : (hit_s ? idx_q : NOTE_NONE);

    // Next-state: FSM, table scan, debounce and note update
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        idx_d    = idx_q;
        found_d  = found_q;
        res_d    = res_q;
        cand_d   = cand_q;
        mc_d     = mc_q;
        note_d   = note_q;
        valid_d  = 1'b0;
        locked_d = locked_q;

        if (!enable || timeout_s) begin
            state_d = ST_IDLE;
            cand_d  = NOTE_NONE;
            mc_d    = '0;
            if (note_q != NOTE_NONE) begin
                note_d   = NOTE_NONE;
                valid_d  = 1'b1;
                locked_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (edge_s) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (edge_s) begin
                        h_d     = cnt_q;
                        idx_d   = NOTE_MIN;
                        found_d = 1'b0;
                        res_d   = NOTE_NONE;
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!found_q && hit_s) begin
                        found_d = 1'b1;
                        res_d   = idx_q;
                    end
                    if (idx_q == NOTE_MAX) begin
                        state_d = ST_ARMED;
                        if (scan_res_s == cand_q) begin
                            if (mc_q != STABLE) begin
                                mc_d = mc_q + CW'(1);
                            end
                        end else begin
                            cand_d = scan_res_s;
                            mc_d   = CW'(1);
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (mc_q == STABLE && cand_q != note_q) begin
                note_d   = cand_q;
                valid_d  = 1'b1;
                locked_d = (cand_q != NOTE_NONE);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            h_q      <= '0;
            idx_q    <= '0;
            found_q  <= 1'b0;
            res_q    <= '0;
            cand_q   <= '0;
            mc_q     <= '0;
            note_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            h_q      <= h_d;
            idx_q    <= idx_d;
            found_q  <= found_d;
            res_q    <= res_d;
            cand_q   <= cand_d;
            mc_q     <= mc_d;
            note_q   <= note_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
        end
    end

    assign note       = note_q;
    assign note_valid = valid_q;
    assign locked     = locked_q;

endmodule
